pll_lock_supervisor: RTL

Sequences the system PLL out of reset and generates the design-wide reset from its lock status. Runs on the 50 MHz board reference clock (the PLL input clock, so it never depends on a PLL output). Drives the PLL `rst` input, watches the PLL `locked` output, and releases `sys_rst` only after lock has been continuously stable. Re-runs the sequence on loss of lock and flags a hard failure after repeated lock timeouts.

---
 rtl/pll_lock_supervisor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing and lock-qualified system reset generation
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRY           = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Terminal counts: a state lasting N cycles leaves when cnt (cleared on entry) hits N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       llc_q, llc_d;
  logic             meta_q, meta_d;
  logic             lock_s_q, lock_s_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             restart;

  // Next-state, counter, retry and lock-loss bookkeeping; outputs decode the next state.
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    llc_d    = llc_q;
    restart  = 1'b0;
    meta_d   = pll_locked;
    lock_s_d = meta_q;

    // A lock loss in RUN is counted even when a soft request wins the transition.
    if ((state_q == S_RUN) && !lock_s_q && (llc_q != 8'hFF)) begin
      llc_d = llc_q + 8'd1;
    end

    if (soft_rst_req) begin
      state_d = S_RESET_PLL;
      restart = 1'b1;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            restart = 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABILIZE;
            restart = 1'b1;
          end else if (cnt_q == TIMEOUT_LAST) begin
            restart = 1'b1;
            retry_d = retry_q + 4'd1;
            state_d = ((retry_q + 4'd1) == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
          end
        end
        S_STABILIZE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            restart = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            restart = 1'b1;
            retry_d = 4'd0;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_RESET_PLL;
            restart = 1'b1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_RESET_PLL;
          restart = 1'b1;
        end
      endcase
    end

    // RUN and FAIL have no timed exit, so the counter is parked there.
    if (restart) begin
      cnt_d = '0;
    end else if ((state_q == S_RUN) || (state_q == S_FAIL)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  // State, counter, synchronizer and registered outputs; reset forces the PLL into reset.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      llc_q     <= 8'd0;
      meta_q    <= 1'b0;
      lock_s_q  <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      llc_q     <= llc_d;
      meta_q    <= meta_d;
      lock_s_q  <= lock_s_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign fail            = fail_q;
  assign lock_loss_count = llc_q;

endmodule
